// File: rtl/lrc_pkg.sv
// Shared types and constants for the LRC frame generator and checker.
package lrc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEN   = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LRC     = 2'd1,
    ERR_BADLEN  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [7:0] SOF_DEFAULT = 8'h3A;

endpackage

// File: rtl/lrc_accum.sv
// 8-bit modulo-256 running sum with clear/load/add and a zero flag.
// The flag looks at sum+din so a trailing LRC byte can be judged in its own cycle.
module lrc_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       add,
  input  logic [7:0] din,
  output logic       zero
);

  logic [7:0] sum_q, sum_d, sum_add;

  assign sum_add = sum_q + din;
  assign zero    = (sum_add == 8'h00);

  always_comb begin
    sum_d = sum_q;
    if (clr)       sum_d = 8'h00;
    else if (load) sum_d = din;
    else if (add)  sum_d = sum_add;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= 8'h00;
    else        sum_q <= sum_d;
  end

endmodule

// File: rtl/lrc_frame_checker.sv
// Byte-serial frame parser (SOF, LEN, payload, LRC) with payload forwarding,
// per-frame pass/fail status and saturating good/bad counters.
//
// state    | meaning
// ST_IDLE  | hunting for SOF, other bytes dropped
// ST_LEN   | expecting the length byte
// ST_DATA  | forwarding payload, remaining bytes counted down
// ST_CHECK | expecting the LRC byte
module lrc_frame_checker
  import lrc_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 16,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       pld_data,
  output logic             pld_valid,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam int                IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

  state_t            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0]        pld_data_q, pld_data_d;
  logic              pld_valid_q, pld_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
  err_t              err_q, err_d;
  logic [CNT_W-1:0]  good_q, good_d, bad_q, bad_d;

  logic acc_clr, acc_load, acc_add, acc_zero;
  logic timeout_hit, len_bad, end_frame;
  err_t end_err;

  lrc_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .load  (acc_load),
    .add   (acc_add),
    .din   (in_data),
    .zero  (acc_zero)
  );

  // Idle timer is a down-counter reloaded on every byte; a byte in the expiry cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && (state_q != ST_IDLE) && !in_valid &&
                       (idle_q == IDLE_W'(1));
  assign len_bad     = (in_data == 8'h00) || (in_data > MAX_LEN_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= 8'h00;
      idle_q       <= '0;
      pld_data_q   <= 8'h00;
      pld_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_q        <= ERR_NONE;
      good_q       <= '0;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      idle_q       <= idle_d;
      pld_data_q   <= pld_data_d;
      pld_valid_q  <= pld_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_q        <= err_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid && in_data == SOF) state_d = ST_LEN;
      ST_LEN: begin
        if (in_valid)         state_d = len_bad ? ST_IDLE : ST_DATA;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (in_valid) begin
          if (rem_q == 8'd1) state_d = ST_CHECK;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: if (in_valid || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_clr      = 1'b0;
    acc_load     = 1'b0;
    acc_add      = 1'b0;
    rem_d        = rem_q;
    pld_data_d   = pld_data_q;
    pld_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_d        = err_q;
    good_d       = good_q;
    bad_d        = bad_q;
    end_frame    = 1'b0;
    end_err      = ERR_NONE;

    if (state_q == ST_IDLE || in_valid) idle_d = IDLE_LOAD;
    else if (idle_q != '0)              idle_d = idle_q - IDLE_W'(1);
    else                                idle_d = idle_q;

    case (state_q)
      ST_IDLE: if (in_valid && in_data == SOF) acc_clr = 1'b1;
      ST_LEN: begin
        if (in_valid) begin
          if (len_bad) begin
            end_frame = 1'b1;
            end_err   = ERR_BADLEN;
          end else begin
            acc_load = 1'b1;
            rem_d    = in_data;
          end
        end else if (timeout_hit) begin
          end_frame = 1'b1;
          end_err   = ERR_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (in_valid) begin
          acc_add     = 1'b1;
          rem_d       = rem_q - 8'd1;
          pld_data_d  = in_data;
          pld_valid_d = 1'b1;
        end else if (timeout_hit) begin
          end_frame = 1'b1;
          end_err   = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (in_valid) begin
          end_frame = 1'b1;
          end_err   = acc_zero ? ERR_NONE : ERR_LRC;
        end else if (timeout_hit) begin
          end_frame = 1'b1;
          end_err   = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (end_frame) begin
      frame_done_d = 1'b1;
      frame_ok_d   = (end_err == ERR_NONE);
      err_d        = end_err;
      if (end_err == ERR_NONE) begin
        if (good_q != '1) good_d = good_q + CNT_W'(1);
      end else begin
        if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
      end
    end
  end

  assign pld_data   = pld_data_q;
  assign pld_valid  = pld_valid_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_code   = err_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;

endmodule
